// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a block-level miss FSM toward data_memory.
// Optional hit/miss counters are compiled in when DCACHE_PERF_CNT_EN is defined.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT,
`endif
    output logic [1:0]   DBG_STATE
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];
    logic [27:0]        miss_blk_q;
    logic [27:0]        mem_addr_q;
    logic [127:0]       mem_wdata_q;
    logic               mem_read_q;
    logic               mem_write_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [1:0]            req_word;
    logic                  access;
    logic                  hit;
    logic                  idle;
    logic                  rd_hit;
    logic                  wr_hit;
    logic                  miss;
    logic                  victim_dirty;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  unused_addr_bits;

    // Handshake: READ/WRITE are level requests held until BUSYWAIT is low;
    // the access completes on the posedge at which BUSYWAIT is low.
    assign req_idx          = ADDRESS[3+INDEX_BITS:4];
    assign req_tag          = ADDRESS[31:4+INDEX_BITS];
    assign req_word         = ADDRESS[3:2];
    assign unused_addr_bits = ^ADDRESS[1:0];

    assign access       = READ ^ WRITE;
    assign idle         = (state_q == S_IDLE);
    assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rd_hit       = idle && access && READ && hit;
    assign wr_hit       = idle && access && WRITE && hit;
    assign miss         = idle && access && !hit;
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

    assign fill_idx = miss_blk_q[INDEX_BITS-1:0];
    assign fill_tag = miss_blk_q[27:INDEX_BITS];

    assign READDATA      = (rd_hit && !RESET) ? data_q[req_idx][{req_word, 5'd0} +: 32] : 32'd0;
    assign BUSYWAIT      = !RESET && (!idle || miss);
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign DBG_STATE     = state_q;

    // Miss FSM; memory-side outputs are registered and change only on state transitions.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_blk_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_hit) begin
                        dirty_q[req_idx] <= 1'b1;
                    end else if (miss) begin
                        miss_blk_q <= ADDRESS[31:4];
                        if (victim_dirty) begin
                            state_q     <= S_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[req_idx], req_idx};
                            mem_wdata_q <= data_q[req_idx];
                        end else begin
                            state_q    <= S_FETCH;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= ADDRESS[31:4];
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q     <= S_FETCH;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= miss_blk_q;
                        mem_wdata_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q    <= S_ALLOCATE;
                        mem_read_q <= 1'b0;
                        mem_addr_q <= '0;
                    end
                end
                S_ALLOCATE: begin
                    state_q           <= S_IDLE;
                    valid_q[fill_idx] <= 1'b1;
                    dirty_q[fill_idx] <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays hold no reset; valid_q alone qualifies their contents.
    always_ff @(posedge CLK) begin
        if (wr_hit && !RESET) begin
            data_q[req_idx][{req_word, 5'd0} +: 32] <= WRITEDATA;
        end else if (state_q == S_ALLOCATE) begin
            data_q[fill_idx] <= MEM_READDATA;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit || wr_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: driver tasks push expectations, a negedge monitor pops and compares them.
module tb_data_cache;
  logic         clk;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] mem_rdata;
  logic         mem_busy;
  logic [1:0]   dbg_state;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_checks = 0;
  int n_errs = 0;

  logic [31:0]  exp_rd_q[$];
  logic [156:0] exp_mem_q[$];

  data_cache dut (
    .CLK(clk), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(mem_rdata), .MEM_BUSYWAIT(mem_busy),
`ifdef DCACHE_PERF_CNT_EN
    .HIT_COUNT(hit_count), .MISS_COUNT(miss_count),
`endif
    .DBG_STATE(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: initial block contents are a pattern, writebacks go to an overlay
  function automatic logic [127:0] blk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = {8'hA0, 8'(b), 8'h00, 8'(w)};
    return r;
  endfunction

  logic [127:0] mem_wr [0:31];
  logic [31:0]  mem_wv = '0;
  int           mcnt = 0;

  assign mem_busy = (MEM_READ || MEM_WRITE) && (mcnt != 2);

  always @(posedge clk) begin
    if ((MEM_READ || MEM_WRITE) && !RESET) begin
      if (mcnt == 2) begin
        mcnt <= 0;
        if (MEM_WRITE) begin
          mem_wr[MEM_ADDRESS[4:0]] <= MEM_WRITEDATA;
          mem_wv[MEM_ADDRESS[4:0]] <= 1'b1;
        end else begin
          mem_rdata <= mem_wv[MEM_ADDRESS[4:0]] ? mem_wr[MEM_ADDRESS[4:0]] : blk(int'(MEM_ADDRESS[4:0]));
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!RESET) begin
      if (READ && !WRITE && !BUSYWAIT) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL rd_unexpected: got %h expected no read", READDATA);
        end else begin
          check("rd_data", {96'd0, READDATA}, {96'd0, exp_rd_q.pop_front()});
        end
      end
      if ((MEM_READ || MEM_WRITE) && !mem_busy) begin
        if (exp_mem_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL mem_unexpected: got rd=%0b wr=%0b addr %h expected none", MEM_READ, MEM_WRITE, MEM_ADDRESS);
        end else begin
          logic [156:0] e;
          e = exp_mem_q.pop_front();
          check("mem_kind", {127'd0, MEM_WRITE}, {127'd0, e[156]});
          check("mem_excl", {127'd0, MEM_READ && MEM_WRITE}, 128'd0);
          check("mem_addr", {100'd0, MEM_ADDRESS}, {100'd0, e[155:128]});
          if (e[156]) check("wb_data", MEM_WRITEDATA, e[127:0]);
        end
      end
    end
  end

  // driver tasks
  function automatic void push_fetch(input int b);
    exp_mem_q.push_back({1'b0, 28'(b), 128'd0});
  endfunction

  function automatic void push_wb(input int b, input logic [127:0] d);
    exp_mem_q.push_back({1'b1, 28'(b), d});
  endfunction

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
  endtask

  task automatic finish_req();
    int n;
    n = 0;
    @(negedge clk);
    while (BUSYWAIT && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("req_done", {127'd0, BUSYWAIT}, 128'd0);
    @(posedge clk); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    exp_rd_q.push_back(exp);
    start_req(1'b1, 1'b0, a, 32'd0);
    finish_req();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    start_req(1'b0, 1'b1, a, d);
    finish_req();
  endtask

  function automatic logic [31:0] wd(input int b, input int w);
    logic [127:0] t;
    t = blk(b);
    return t[w*32 +: 32];
  endfunction

  initial begin
    logic [127:0] v;
    int n;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busywait", {127'd0, BUSYWAIT}, 128'd0);
    RESET = 1'b0;
    #1;
    check("rst_mem_read", {127'd0, MEM_READ}, 128'd0);
    check("rst_mem_write", {127'd0, MEM_WRITE}, 128'd0);
    check("rst_readdata", {96'd0, READDATA}, 128'd0);
    check("rst_mem_addr", {100'd0, MEM_ADDRESS}, 128'd0);
    check("rst_mem_wdata", MEM_WRITEDATA, 128'd0);
    @(posedge clk); #1;

    // cold read miss of block 1
    push_fetch(1);
    exp_rd_q.push_back(wd(1, 0));
    start_req(1'b1, 1'b0, 32'h10, 32'd0);
    #1;
    check("miss_busywait", {127'd0, BUSYWAIT}, 128'd1);
    @(posedge clk); #1;
    check("fetch_mem_read", {127'd0, MEM_READ}, 128'd1);
    check("fetch_mem_addr", {100'd0, MEM_ADDRESS}, 128'd1);
    finish_req();

    // write hit, then read back with no memory traffic
    start_req(1'b0, 1'b1, 32'h14, 32'hDEADBEEF);
    #1;
    check("wr_hit_busywait", {127'd0, BUSYWAIT}, 128'd0);
    finish_req();
    exp_rd_q.push_back(32'hDEADBEEF);
    start_req(1'b1, 1'b0, 32'h14, 32'd0);
    #1;
    check("rd_hit_busywait", {127'd0, BUSYWAIT}, 128'd0);
    check("rd_hit_mem_read", {127'd0, MEM_READ}, 128'd0);
    finish_req();

    // dirty eviction of block 1 by block 9
    v = blk(1);
    v[63:32] = 32'hDEADBEEF;
    push_wb(1, v);
    push_fetch(9);
    do_read(32'h94, wd(9, 1));

    // clean eviction at index 2: fetch only
    push_fetch(2);
    do_read(32'h20, wd(2, 0));
    push_fetch(10);
    do_read(32'hA8, wd(10, 2));

    // written-back data comes back from memory
    push_fetch(1);
    do_read(32'h14, 32'hDEADBEEF);

    // write-allocate miss, then dirty eviction of the merged line
    push_fetch(3);
    do_write(32'h34, 32'h12345678);
    do_read(32'h34, 32'h12345678);
    do_read(32'h30, wd(3, 0));
    v = blk(3);
    v[63:32] = 32'h12345678;
    push_wb(3, v);
    push_fetch(11);
    do_read(32'hB0, wd(11, 0));

    // reset during fetch
    start_req(1'b1, 1'b0, 32'h40, 32'd0);
    @(posedge clk); #1;
    check("pre_rst_mem_read", {127'd0, MEM_READ}, 128'd1);
    RESET = 1'b1;
    #1;
    check("mid_rst_mem_read", {127'd0, MEM_READ}, 128'd0);
    check("mid_rst_busywait", {127'd0, BUSYWAIT}, 128'd0);
    check("mid_rst_readdata", {96'd0, READDATA}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    push_fetch(4);
    exp_rd_q.push_back(wd(4, 0));
    RESET = 1'b0;
    #1;
    check("post_rst_miss", {127'd0, BUSYWAIT}, 128'd1);
    finish_req();

    // READ and WRITE together: no access
    start_req(1'b1, 1'b1, 32'h50, 32'h0BADF00D);
    #1;
    check("illegal_busywait", {127'd0, BUSYWAIT}, 128'd0);
    check("illegal_readdata", {96'd0, READDATA}, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    check("illegal_mem_req", {126'd0, MEM_READ, MEM_WRITE}, 128'd0);
    READ = 1'b0; WRITE = 1'b0;
    push_fetch(5);
    do_read(32'h50, wd(5, 0));

    // request dropped mid-miss: fill still completes
    push_fetch(6);
    start_req(1'b1, 1'b0, 32'h60, 32'd0);
    @(posedge clk); #1;
    READ = 1'b0;
    #1;
    check("drop_busywait", {127'd0, BUSYWAIT}, 128'd1);
    n = 0;
    while (BUSYWAIT && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("drop_drain", {127'd0, BUSYWAIT}, 128'd0);
    @(posedge clk); #1;
    exp_rd_q.push_back(wd(6, 1));
    start_req(1'b1, 1'b0, 32'h64, 32'd0);
    #1;
    check("drop_then_hit", {127'd0, BUSYWAIT}, 128'd0);
    finish_req();

    // fresh run: 3 misses + 5 hits
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    push_fetch(0);
    do_read(32'h00, wd(0, 0));
    push_fetch(1);
    do_read(32'h10, wd(1, 0));
    push_fetch(2);
    do_read(32'h20, wd(2, 0));
    do_read(32'h04, wd(0, 1));
    do_read(32'h14, 32'hDEADBEEF);
`ifdef DCACHE_PERF_CNT_EN
    check("miss_count", {96'd0, miss_count}, 128'd3);
    check("hit_count", {96'd0, hit_count}, 128'd5);
`endif

    repeat (3) @(posedge clk);
    check("rd_q_empty", 128'(exp_rd_q.size()), 128'd0);
    check("mem_q_empty", 128'(exp_mem_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
